// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and data access.
// Serialises requests, stalls the pipeline, routes read data back.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t     state;
  logic [3:0] cnt;
  logic       fetch_starved;
  logic       owner_d;
  logic       owner_we;
  logic       grant_if;

  // Fetch wins only when data is absent or fetch lost the last contest
  assign grant_if = if_req & (~d_req | fetch_starved);

  // Hold the pipeline while any request is still waiting for completion
  assign stall = reset &
                 ((if_req & ~if_valid) | (d_req & ~d_done));

  // Transaction sequencer with registered strobes and read-data capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      fetch_starved <= 1'b0;
      owner_d       <= 1'b0;
      owner_we      <= 1'b0;
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      if_valid      <= 1'b0;
      d_done        <= 1'b0;
      if_rdata      <= '0;
      d_rdata       <= '0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_valid <= 1'b0;
      d_done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (if_req | d_req) begin
            owner_d   <= ~grant_if;
            owner_we  <= ~grant_if & d_we;
            mem_addr  <= grant_if ? if_addr : d_addr;
            mem_wdata <= grant_if ? '0 : d_wdata;
            mem_en    <= 1'b1;
            mem_we    <= ~grant_if & d_we;
            if (grant_if)
              fetch_starved <= 1'b0;
            else if (if_req)
              fetch_starved <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= LAT;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) begin
            if (owner_d) begin
              d_done <= 1'b1;
              if (!owner_we)
                d_rdata <= mem_rdata;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter.
// A transaction-timing model predicts every output each cycle.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, d_done, stall, mem_en, mem_we;

  logic        l1_req, l15_req;
  logic [31:0] l1_rd, l15_rd;
  logic [31:0] l1_ird, l1_drd, l1_ma, l1_mw;
  logic [31:0] l15_ird, l15_drd, l15_ma, l15_mw;
  logic        l1_ifv, l1_dd, l1_st, l1_en, l1_we;
  logic        l15_ifv, l15_dd, l15_st, l15_en, l15_we;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'd0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // model state: one outstanding transaction described by its start cycle
  bit          busy = 0;
  bit          starved = 0;
  int          t_start;
  bit          t_d, t_we;
  logic [31:0] t_addr, t_wdata;
  logic [31:0] m_if_rdata = 0, m_d_rdata = 0;
  bit          last_ifv = 0, last_dd = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset),
    .if_req(l1_req), .if_addr(zero32),
    .if_rdata(l1_ird), .if_valid(l1_ifv),
    .d_req(zero1), .d_we(zero1), .d_addr(zero32), .d_wdata(zero32),
    .d_rdata(l1_drd), .d_done(l1_dd), .stall(l1_st),
    .mem_en(l1_en), .mem_we(l1_we), .mem_addr(l1_ma),
    .mem_wdata(l1_mw), .mem_rdata(l1_rd)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) u15 (
    .clk(clk), .reset(reset),
    .if_req(l15_req), .if_addr(zero32),
    .if_rdata(l15_ird), .if_valid(l15_ifv),
    .d_req(zero1), .d_we(zero1), .d_addr(zero32), .d_wdata(zero32),
    .d_rdata(l15_drd), .d_done(l15_dd), .stall(l15_st),
    .mem_en(l15_en), .mem_we(l15_we), .mem_addr(l15_ma),
    .mem_wdata(l15_mw), .mem_rdata(l15_rd)
  );

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h",
               name, cyc, act, exp);
    end
  endtask

  // start of a cycle: inputs for this cycle are set after this returns
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mem_rdata = $urandom;
  endtask

  // mid-cycle compare against the model, then advance the model
  task automatic check();
    int  rel;
    bit  e_en, e_we, e_ifv, e_dd, e_st, win_if;
    @(negedge clk);
    rel   = cyc - t_start;
    e_en  = busy && rel == 1;
    e_we  = e_en && t_d && t_we;
    e_ifv = busy && rel == LAT + 2 && !t_d;
    e_dd  = busy && rel == LAT + 2 && t_d;
    e_st  = reset && ((if_req && !e_ifv) || (d_req && !e_dd));
    cmp("mem_en", 32'(mem_en), 32'(e_en));
    cmp("mem_we", 32'(mem_we), 32'(e_we));
    cmp("if_valid", 32'(if_valid), 32'(e_ifv));
    cmp("d_done", 32'(d_done), 32'(e_dd));
    cmp("stall", 32'(stall), 32'(e_st));
    if (e_en) cmp("mem_addr", mem_addr, t_addr);
    if (e_we) cmp("mem_wdata", mem_wdata, t_wdata);
    if (e_ifv) cmp("if_rdata", if_rdata, m_if_rdata);
    if (e_dd) cmp("d_rdata", d_rdata, m_d_rdata);
    last_ifv = if_valid;
    last_dd  = d_done;
    if (!reset) begin
      busy = 0;
      starved = 0;
      m_if_rdata = 0;
      m_d_rdata = 0;
    end else if (busy) begin
      if (rel == LAT + 1) begin
        if (!t_d) m_if_rdata = mem_rdata;
        else if (!t_we) m_d_rdata = mem_rdata;
      end
      if (rel == LAT + 2) busy = 0;
    end else if (if_req || d_req) begin
      win_if = if_req && (!d_req || starved);
      if (win_if) starved = 0;
      else if (if_req) starved = 1;
      busy    = 1;
      t_start = cyc;
      t_d     = !win_if;
      t_we    = !win_if && d_we;
      t_addr  = win_if ? if_addr : d_addr;
      t_wdata = d_wdata;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check();
    end
  endtask

  initial begin
    int got1, got15;
    reset = 0; if_req = 0; d_req = 0; d_we = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    l1_req = 0; l15_req = 0;
    l1_rd = 32'h1111_0001; l15_rd = 32'h1515_0015;

    // reset state
    run(2);
    cmp("rst mem_addr", mem_addr, 0);
    cmp("rst mem_wdata", mem_wdata, 0);
    cmp("rst if_rdata", if_rdata, 0);
    cmp("rst d_rdata", d_rdata, 0);
    cmp("rst mem_en", 32'(mem_en), 0);

    // fetch only
    tick(); reset = 1; if_req = 1; if_addr = 32'h10; check();
    cmp("f C0 stall", 32'(stall), 1);
    tick(); check();
    cmp("f C1 mem_en", 32'(mem_en), 1);
    cmp("f C1 mem_addr", mem_addr, 32'h10);
    tick(); check();
    cmp("f C2 mem_en", 32'(mem_en), 0);
    tick(); mem_rdata = 32'hDEADBEEF; check();
    cmp("f C3 stall", 32'(stall), 1);
    tick(); check();
    cmp("f C4 if_valid", 32'(if_valid), 1);
    cmp("f C4 if_rdata", if_rdata, 32'hDEADBEEF);
    cmp("f C4 stall", 32'(stall), 0);
    tick(); if_req = 0; check();
    cmp("f C5 if_valid", 32'(if_valid), 0);

    // contention: data wins, fetch follows one transaction later
    tick(); if_req = 1; if_addr = 32'h20;
    d_req = 1; d_we = 0; d_addr = 32'h80; check();
    tick(); check();
    cmp("c C1 mem_addr", mem_addr, 32'h80);
    tick(); check();
    tick(); mem_rdata = 32'hA5A50001; check();
    tick(); check();
    cmp("c C4 d_done", 32'(d_done), 1);
    cmp("c C4 d_rdata", d_rdata, 32'hA5A50001);
    tick(); d_req = 0; check();
    tick(); check();
    cmp("c C6 mem_en", 32'(mem_en), 1);
    cmp("c C6 mem_addr", mem_addr, 32'h20);
    run(1);
    tick(); check();
    cmp("c C8 stall", 32'(stall), 1);
    tick(); check();
    cmp("c C9 if_valid", 32'(if_valid), 1);
    tick(); if_req = 0; check();

    // store leaves d_rdata untouched
    tick(); d_req = 1; d_we = 1; d_addr = 32'h40;
    d_wdata = 32'h12345678; check();
    tick(); check();
    cmp("s C1 mem_we", 32'(mem_we), 1);
    cmp("s C1 mem_addr", mem_addr, 32'h40);
    cmp("s C1 mem_wdata", mem_wdata, 32'h12345678);
    run(2);
    tick(); check();
    cmp("s C4 d_done", 32'(d_done), 1);
    cmp("s C4 d_rdata", d_rdata, 32'hA5A50001);
    tick(); d_req = 0; d_we = 0; check();

    // starvation guard
    tick(); if_req = 1; if_addr = 32'h30;
    d_req = 1; d_addr = 32'h50; check();
    run(3);
    tick(); check();
    cmp("g C4 d_done", 32'(d_done), 1);
    tick(); d_addr = 32'h54; check();
    tick(); check();
    cmp("g C6 mem_addr", mem_addr, 32'h30);
    run(2);
    tick(); check();
    cmp("g C9 if_valid", 32'(if_valid), 1);
    tick(); if_addr = 32'h34; check();
    tick(); check();
    cmp("g C11 mem_addr", mem_addr, 32'h54);
    run(3);
    tick(); d_req = 0; check();
    run(4);
    tick(); if_req = 0; check();

    // reset while a load is in WAIT
    tick(); d_req = 1; d_we = 0; d_addr = 32'h60; check();
    run(1);
    tick(); reset = 0; check();
    tick(); reset = 1; d_req = 0;
    mem_rdata = 32'hCAFEF00D; check();
    cmp("r C3 mem_en", 32'(mem_en), 0);
    cmp("r C3 mem_addr", mem_addr, 0);
    cmp("r C3 d_rdata", d_rdata, 0);
    cmp("r C3 stall", 32'(stall), 0);
    run(6);

    // randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset = ($urandom_range(0, 299) != 0);
      if (if_req && last_ifv) begin
        if_req  = $urandom_range(0, 1);
        if_addr = $urandom;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1;
        if_addr = $urandom;
      end
      if (d_req && last_dd) begin
        d_req   = $urandom_range(0, 1);
        d_we    = $urandom_range(0, 1);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req   = 1;
        d_we    = $urandom_range(0, 1);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      check();
    end
    tick(); reset = 1; if_req = 0; d_req = 0; check();
    run(20);

    // latency at the MEM_LAT extremes
    got1 = -1; got15 = -1;
    tick(); l1_req = 1; l15_req = 1; check();
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        tick();
        check();
      end
      if (l1_ifv && got1 < 0) begin
        got1 = c;
        cmp("lat1 rdata", l1_ird, 32'h1111_0001);
      end
      if (l15_ifv && got15 < 0) begin
        got15 = c;
        cmp("lat15 rdata", l15_ird, 32'h1515_0015);
      end
    end
    cmp("lat1 pulse cycle", 32'(got1), 3);
    cmp("lat15 pulse cycle", 32'(got15), 17);
    l1_req = 0; l15_req = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
